// File: rtl/weighted_vote_tally.sv
// weighted_vote_tally
//   Multi-ballot weighted vote accumulator. A session opens on start and
//   latches the pass threshold. The block then takes one ballot per cycle
//   over a valid/ready handshake. Each ballot's weighted sum goes through a
//   one-deep pipeline stage and is added into a saturating session
//   accumulator. The session ends on close, or automatically once
//   MAX_BALLOTS ballots have been accepted. The final total and the pass
//   verdict are then registered and held, and done pulses for one cycle.
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   start    : open a session (honoured only while idle)
//   thresh   : pass threshold, latched when start is honoured
//   in_valid : ballot present on common/vip/vvip
//   in_ready : ballot accepted on a cycle with in_valid & in_ready
//   common   : common vote bits, W_COMMON each
//   vip      : VIP vote bits, W_VIP each
//   vvip     : single VVIP vote bit, W_VVIP
//   close    : end the session (honoured only while collecting)
//   busy     : a session is in progress (any state but idle)
//   done     : one-cycle pulse when total/pass are updated
//   pass     : final total >= latched threshold, held until next done
//   total    : final saturated session total, held until next done

module weighted_vote_tally #(
  parameter int N_COMMON    = 32,
  parameter int N_VIP       = 8,
  parameter int W_COMMON    = 1,
  parameter int W_VIP       = 4,
  parameter int W_VVIP      = 32,
  parameter int CNT_W       = 16,
  parameter int MAX_BALLOTS = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    thresh,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_COMMON-1:0] common,
  input  logic [N_VIP-1:0]    vip,
  input  logic                vvip,
  input  logic                close,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    total
);

  localparam int MAX_SUM = N_COMMON * W_COMMON + N_VIP * W_VIP + W_VVIP;
  localparam int SUM_W   = $clog2(MAX_SUM + 1);
  // One spare bit above the wider operand so the carry out of the add
  // flags saturation even if a single ballot can exceed the total width.
  localparam int ADD_W   = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;
  localparam int BCNT_W  = $clog2(MAX_BALLOTS + 1);

  localparam logic [ADD_W-1:0] SAT_EXT = {{(ADD_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] SAT_VAL = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q;
  logic                inReady_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [CNT_W-1:0]    total_q;
  logic [CNT_W-1:0]    acc_q;
  logic [CNT_W-1:0]    thresh_q;
  logic [BCNT_W-1:0]   ballotCnt_q;
  logic                stageValid_q;
  logic [SUM_W-1:0]    stageSum_q;

  logic [SUM_W-1:0]    ballotSum;
  logic [ADD_W-1:0]    accExt;
  logic [CNT_W-1:0]    acc_d;
  logic [BCNT_W-1:0]   ballotCnt_d;
  logic                accept;

  // Weighted sum of the ballot currently on the inputs.
  always_comb begin
    ballotSum = '0;
    for (int i = 0; i < N_COMMON; i++) begin
      if (common[i]) ballotSum = ballotSum + SUM_W'(W_COMMON);
    end
    for (int i = 0; i < N_VIP; i++) begin
      if (vip[i]) ballotSum = ballotSum + SUM_W'(W_VIP);
    end
    if (vvip) ballotSum = ballotSum + SUM_W'(W_VVIP);
  end

  // Accumulator value after folding in the staged ballot, clamped at the
  // largest representable total so it can never wrap.
  always_comb begin
    accExt = ADD_W'(acc_q) + ADD_W'(stageSum_q);
    acc_d  = acc_q;
    if (stageValid_q) begin
      acc_d = (accExt > SAT_EXT) ? SAT_VAL : accExt[CNT_W-1:0];
    end
  end

  assign accept      = in_valid && inReady_q;
  assign ballotCnt_d = ballotCnt_q + 1'b1;

  // Session FSM, ballot pipeline and result registers. The handshake and
  // status outputs are registered and move together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      inReady_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      total_q      <= '0;
      acc_q        <= '0;
      thresh_q     <= '0;
      ballotCnt_q  <= '0;
      stageValid_q <= 1'b0;
      stageSum_q   <= '0;
    end else begin
      stageValid_q <= accept;
      if (accept) stageSum_q <= ballotSum;
      if (stageValid_q) acc_q <= acc_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q       <= '0;
            ballotCnt_q <= '0;
            thresh_q    <= thresh;
            inReady_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) ballotCnt_q <= ballotCnt_d;
          // A ballot arriving with close is accepted before the session ends.
          if (close || (accept && (ballotCnt_d == BCNT_W'(MAX_BALLOTS)))) begin
            inReady_q <= 1'b0;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          // The last staged ballot lands this edge, so publish acc_d directly.
          total_q <= acc_d;
          pass_q  <= (acc_d >= thresh_q);
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          inReady_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = inReady_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign total    = total_q;

endmodule
